// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential ROM word fetch with bounded outstanding requests,
// a PC-tagged first-word-fall-through FIFO toward decode, and redirect flush with stale-response drop.
module fetch_queue #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        i_req_o,
   output logic [31:0] i_address_o,
   input  logic        i_gnt_i,
   input  logic        i_rvalid_i,
   input  logic [31:0] i_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
);

   localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam int          OW      = $clog2(MAX_OUTST + 1);
   localparam logic [31:0] DEPTH_U = DEPTH;
   localparam logic [31:0] OUTST_U = MAX_OUTST;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [OW-1:0] r_outst;
   logic [OW-1:0] r_drop;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [31:0]   r_mem_inst [DEPTH];
   logic [31:0]   r_mem_pc   [DEPTH];

   logic [OW-1:0] w_live;
   logic [31:0]   w_fill;
   logic          w_credit;
   logic          w_xfer;
   logic          w_rsp;
   logic          w_push;
   logic          w_pop;
   logic          w_have;
   logic [31:0]   w_redir_pc;
   logic          w_unused;

   // Live requests will land in the FIFO; stale ones only hold a bus slot.
   assign w_live     = r_outst - r_drop;
   assign w_fill     = 32'(r_count) + 32'(w_live);
   assign w_credit   = (32'(r_outst) < OUTST_U) && (w_fill < DEPTH_U);
   assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};
   assign w_unused   = ^redirect_pc_i[1:0];

   assign i_req_o     = reset_n & ~redirect_i & w_credit;
   assign i_address_o = r_fetch_pc;

   assign w_xfer = i_req_o & i_gnt_i;
   assign w_rsp  = i_rvalid_i & (r_outst != '0);
   assign w_push = w_rsp & (r_drop == '0) & ~redirect_i;

   assign w_have       = reset_n & (r_count != '0);
   assign inst_valid_o = w_have & ~redirect_i;
   assign inst_o       = w_have ? r_mem_inst[r_rptr] : 32'h0;
   assign inst_pc_o    = w_have ? r_mem_pc[r_rptr]   : 32'h0;
   assign w_pop        = inst_valid_o & inst_ready_i;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_outst    <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else if (redirect_i) begin
         // Everything still in flight belongs to the old path.
         r_fetch_pc <= w_redir_pc;
         r_resp_pc  <= w_redir_pc;
         r_outst    <= r_outst - OW'(w_rsp);
         r_drop     <= r_outst - OW'(w_rsp);
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         if (w_xfer) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         r_outst <= r_outst + OW'(w_xfer) - OW'(w_rsp);
         if (w_rsp && (r_drop != '0)) begin
            r_drop <= r_drop - 1'b1;
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + 32'd4;
            r_wptr    <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_inst[r_wptr] <= i_rdata_i;
         r_mem_pc[r_wptr]   <= r_resp_pc;
      end
   end

   // A response with nothing outstanding means the ROM side is out of step.
   always_ff @(posedge clk) begin
      if (reset_n && i_rvalid_i) begin
         assert (r_outst != '0);
      end
   end

endmodule
